pll_lock_ctrl: RTL and testbench

PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

---
 rtl/pll_lock_ctrl.sv | 154 +++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: PLL reset / lock-qualification sequencer with bounded retries.
// Revision: 1.0
`default_nettype none

module pll_lock_ctrl #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 1000000,
  parameter int MAX_RETRY    = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked_in,
  input  logic       req_reset,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int c_MAX_AB = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
  localparam int c_MAX    = (c_MAX_AB > LOCK_TIMEOUT) ? c_MAX_AB : LOCK_TIMEOUT;
  localparam int c_CNT_W  = (c_MAX > 1) ? $clog2(c_MAX) : 1;

  localparam logic [c_CNT_W-1:0] c_CNT_ZERO   = '0;
  localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_RST_LAST   = c_CNT_W'(RST_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_STAB_LAST  = c_CNT_W'(LOCK_STABLE - 1);
  localparam logic [c_CNT_W-1:0] c_TOUT_LAST  = c_CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]         c_MAX_RETRY  = 4'(MAX_RETRY);

  localparam logic [2:0] c_ST_RESET_PLL = 3'd0;
  localparam logic [2:0] c_ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] c_ST_STABLE    = 3'd2;
  localparam logic [2:0] c_ST_RUN       = 3'd3;
  localparam logic [2:0] c_ST_FAIL      = 3'd4;

  logic               r_sync1;
  logic               r_locked_s;
  logic [2:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [3:0]         r_retry;
  logic [7:0]         r_loss;

  logic [2:0]         w_state_nxt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [c_CNT_W-1:0] w_cnt_inc;
  logic [3:0]         w_retry_nxt;
  logic [3:0]         w_retry_inc;
  logic [7:0]         w_loss_nxt;
  logic [7:0]         w_loss_sat;

  assign w_cnt_inc   = r_cnt + c_CNT_ONE;
  assign w_retry_inc = r_retry + 4'd1;
  assign w_loss_sat  = (r_loss == 8'hFF) ? r_loss : (r_loss + 8'd1);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_locked_s <= 1'b0;
      r_state    <= c_ST_RESET_PLL;
      r_cnt      <= c_CNT_ZERO;
      r_retry    <= 4'd0;
      r_loss     <= 8'd0;
    end else begin
      r_sync1    <= locked_in;
      r_locked_s <= r_sync1;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_retry    <= w_retry_nxt;
      r_loss     <= w_loss_nxt;
    end
  end

  // Every transition clears the counter; it only increments below its terminal value, so it cannot wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;
    w_loss_nxt  = r_loss;
    if (req_reset) begin
      w_state_nxt = c_ST_RESET_PLL;
      w_cnt_nxt   = c_CNT_ZERO;
      w_retry_nxt = 4'd0;
      if ((r_state == c_ST_RUN) && !r_locked_s) begin
        w_loss_nxt = w_loss_sat;
      end
    end else begin
      case (r_state)
        c_ST_RESET_PLL: begin
          if (r_cnt == c_RST_LAST) begin
            w_state_nxt = c_ST_WAIT_LOCK;
            w_cnt_nxt   = c_CNT_ZERO;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end
        c_ST_WAIT_LOCK: begin
          if (r_locked_s) begin
            w_state_nxt = c_ST_STABLE;
            w_cnt_nxt   = c_CNT_ZERO;
          end else if (r_cnt == c_TOUT_LAST) begin
            w_retry_nxt = w_retry_inc;
            w_cnt_nxt   = c_CNT_ZERO;
            w_state_nxt = (w_retry_inc == c_MAX_RETRY) ? c_ST_FAIL : c_ST_RESET_PLL;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end
        c_ST_STABLE: begin
          if (!r_locked_s) begin
            w_state_nxt = c_ST_WAIT_LOCK;
            w_cnt_nxt   = c_CNT_ZERO;
          end else if (r_cnt == c_STAB_LAST) begin
            w_state_nxt = c_ST_RUN;
            w_cnt_nxt   = c_CNT_ZERO;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end
        c_ST_RUN: begin
          if (!r_locked_s) begin
            w_state_nxt = c_ST_RESET_PLL;
            w_cnt_nxt   = c_CNT_ZERO;
            w_retry_nxt = 4'd0;
            w_loss_nxt  = w_loss_sat;
          end
        end
        c_ST_FAIL: begin
          w_cnt_nxt = c_CNT_ZERO;
        end
        default: begin
          w_state_nxt = c_ST_RESET_PLL;
          w_cnt_nxt   = c_CNT_ZERO;
        end
      endcase
    end
  end

  always_comb begin
    pll_rst   = (r_state == c_ST_RESET_PLL);
    sys_reset = (r_state != c_ST_RUN);
    ready     = (r_state == c_ST_RUN);
    fail      = (r_state == c_ST_FAIL);
  end

  assign retry_cnt = r_retry;
  assign loss_cnt  = r_loss;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_ctrl.sv
// tb_pll_lock_ctrl: directed self-checking bench for pll_lock_ctrl (4/8/32/2 configuration).
// Revision: 1.0
`default_nettype none

module tb_pll_lock_ctrl;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       locked_in;
  logic       req_reset;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pll_lock_ctrl #(
    .RST_CYCLES  (4),
    .LOCK_STABLE (8),
    .LOCK_TIMEOUT(32),
    .MAX_RETRY   (2)
  ) u_dut (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .locked_in(locked_in),
    .req_reset(req_reset),
    .pll_rst  (pll_rst),
    .sys_reset(sys_reset),
    .ready    (ready),
    .fail     (fail),
    .retry_cnt(retry_cnt),
    .loss_cnt (loss_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // Entered at cycle 0 of a RESET_PLL pulse with locked_s high by cycle 4; leaves at cycle 13 (RUN).
  task automatic run_lock_seq(input string tag);
    for (int c = 0; c < 14; c++) begin
      chk($sformatf("%s_pll_rst_c%0d", tag, c), 32'(pll_rst), 32'(c < 4));
      chk($sformatf("%s_ready_c%0d", tag, c), 32'(ready), 32'(c >= 13));
      chk($sformatf("%s_sys_reset_c%0d", tag, c), 32'(sys_reset), 32'(c < 13));
      chk($sformatf("%s_fail_c%0d", tag, c), 32'(fail), 32'd0);
      if (c < 13) tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    locked_in = 1'b1;
    req_reset = 1'b0;
    repeat (3) tick();
    chk("rst_pll_rst", 32'(pll_rst), 32'd1);
    chk("rst_sys_reset", 32'(sys_reset), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_retry", 32'(retry_cnt), 32'd0);
    chk("rst_loss", 32'(loss_cnt), 32'd0);

    // Power-up with a steady lock.
    rst_n = 1'b1;
    run_lock_seq("pwrup");
    chk("pwrup_retry", 32'(retry_cnt), 32'd0);
    chk("pwrup_loss", 32'(loss_cnt), 32'd0);

    // Lock loss in RUN.
    tick();
    locked_in = 1'b0;
    tick();
    tick();
    chk("loss_ready_t2", 32'(ready), 32'd1);
    tick();
    locked_in = 1'b1;
    run_lock_seq("relock");
    chk("relock_loss", 32'(loss_cnt), 32'd1);
    chk("relock_retry", 32'(retry_cnt), 32'd0);

    // One-cycle lock glitch while the STABLE counter is at 5.
    req_reset = 1'b1;
    tick();
    req_reset = 1'b0;
    for (int c = 0; c < 21; c++) begin
      if (c == 8) locked_in = 1'b0;
      if (c == 9) locked_in = 1'b1;
      chk($sformatf("glitch_pll_rst_c%0d", c), 32'(pll_rst), 32'(c < 4));
      chk($sformatf("glitch_ready_c%0d", c), 32'(ready), 32'(c >= 20));
      if (c < 20) tick();
    end
    chk("glitch_loss", 32'(loss_cnt), 32'd1);

    // No lock at all: two timeouts then FAIL.
    locked_in = 1'b0;
    req_reset = 1'b1;
    tick();
    req_reset = 1'b0;
    for (int c = 0; c < 75; c++) begin
      chk($sformatf("to_pll_rst_c%0d", c), 32'(pll_rst), 32'((c < 4) || (c >= 36 && c < 40)));
      chk($sformatf("to_fail_c%0d", c), 32'(fail), 32'(c >= 72));
      chk($sformatf("to_sys_reset_c%0d", c), 32'(sys_reset), 32'd1);
      if (c == 35) chk("to_retry_c35", 32'(retry_cnt), 32'd0);
      if (c == 36) chk("to_retry_c36", 32'(retry_cnt), 32'd1);
      if (c == 72) chk("to_retry_c72", 32'(retry_cnt), 32'd2);
      if (c < 74) tick();
    end
    chk("to_loss", 32'(loss_cnt), 32'd1);

    // Recover from FAIL with req_reset.
    locked_in = 1'b1;
    req_reset = 1'b1;
    tick();
    req_reset = 1'b0;
    chk("refail_retry", 32'(retry_cnt), 32'd0);
    chk("refail_fail", 32'(fail), 32'd0);
    run_lock_seq("refail");

    // req_reset coinciding with lock loss in RUN, then a restart mid-pulse.
    tick();
    locked_in = 1'b0;
    tick();
    tick();
    req_reset = 1'b1;
    tick();
    req_reset = 1'b0;
    locked_in = 1'b1;
    chk("coinc_loss", 32'(loss_cnt), 32'd2);
    chk("coinc_pll_rst", 32'(pll_rst), 32'd1);
    tick();
    req_reset = 1'b1;
    tick();
    req_reset = 1'b0;
    run_lock_seq("restart");
    chk("restart_loss", 32'(loss_cnt), 32'd2);

    // Asynchronous reset during STABLE.
    req_reset = 1'b1;
    tick();
    req_reset = 1'b0;
    repeat (6) tick();
    chk("async_pre_ready", 32'(ready), 32'd0);
    chk("async_pre_pll_rst", 32'(pll_rst), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pll_rst", 32'(pll_rst), 32'd1);
    chk("async_ready", 32'(ready), 32'd0);
    chk("async_sys_reset", 32'(sys_reset), 32'd1);
    chk("async_loss", 32'(loss_cnt), 32'd0);
    chk("async_retry", 32'(retry_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    run_lock_seq("rst_rel");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
